// File: rtl/encoder_4to2_sync.sv
// Debounced 4-to-2 priority encoder with a one-entry valid/ready output register.
// Requests are synchronized, filtered per line, and their rising edges are encoded (d3 highest).
module encoder_4to2_sync #(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic ready,
  output logic a,
  output logic b,
  output logic valid,
  output logic multi,
  output logic ovf
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic [3:0] sync1, sync2;
  logic [3:0] filt, filt_q;
  logic [3:0] cnt [4];
  logic [3:0] rise;

  state_t     state, state_nxt;
  logic [1:0] code, code_nxt;
  logic       multi_nxt;
  logic       ovf_nxt;
  logic [1:0] ev_code;
  logic       ev_multi;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {d3, d2, d1, d0};
      sync2 <= sync1;
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset along with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= '0;
      filt_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      filt_q <= filt;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == 4'(DEB - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  assign rise = filt & ~filt_q;

  // Clearing the lowest set bit leaves something only when two or more lines rose.
  always_comb begin
    ev_multi = |(rise & (rise - 4'd1));
    if (rise[3])      ev_code = 2'd3;
    else if (rise[2]) ev_code = 2'd2;
    else if (rise[1]) ev_code = 2'd1;
    else              ev_code = 2'd0;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    multi_nxt = multi;
    ovf_nxt   = ovf;
    case (state)
      EMPTY: begin
        if (|rise) begin
          state_nxt = FULL;
          code_nxt  = ev_code;
          multi_nxt = ev_multi;
        end
      end
      FULL: begin
        if (ready) begin
          if (|rise) begin
            code_nxt  = ev_code;
            multi_nxt = ev_multi;
          end else begin
            state_nxt = EMPTY;
          end
        end else if (|rise) begin
          ovf_nxt = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      code  <= '0;
      multi <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      code  <= code_nxt;
      multi <= multi_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign valid = (state == FULL);
  assign a     = code[1];
  assign b     = code[0];

endmodule

// File: tb/tb_encoder_4to2_sync.sv
// Directed testbench for encoder_4to2_sync with DEB=4: latency, glitch rejection,
// priority/multi, overflow, back-to-back accept and asynchronous reset.
module tb_encoder_4to2_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic ready = 1'b0;
  logic a, b, valid, multi, ovf;

  int n_cmp = 0;
  int n_err = 0;

  encoder_4to2_sync #(.DEB(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .ready (ready),
    .a     (a),
    .b     (b),
    .valid (valid),
    .multi (multi),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for valid; a timeout counts as a failed comparison.
  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s: valid never rose (got %b, want 1)", name, valid);
    end
  endtask

  task automatic expect_out(input string name, input logic [4:0] want);
    n_cmp++;
    if ({valid, a, b, multi, ovf} !== want) begin
      n_err++;
      $display("FAIL %s: {valid,a,b,multi,ovf} got %b want %b", name, {valid, a, b, multi, ovf}, want);
    end
  endtask

  task automatic test_reset();
    #3;
    expect_out("reset_hold", 5'b00000);
    tick(3);
    expect_out("reset_after_edges", 5'b00000);
    rst = 1'b0;
  endtask

  task automatic test_latency();
    ready = 1'b1;
    d2    = 1'b1;
    tick(6);
    expect_out("latency_not_early", 5'b00000);
    tick();
    expect_out("latency_event_d2", 5'b11000);
    tick();
    expect_out("latency_accepted", 5'b01000);
    d2 = 1'b0;
    tick(12);
    expect_out("fall_no_event", 5'b01000);
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    d1 = 1'b1;
    tick(3);
    d1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid !== 1'b0 || ovf !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_no_event: output activity got 1 want 0");
    end
  endtask

  task automatic test_multi();
    ready = 1'b0;
    d0 = 1'b1;
    d3 = 1'b1;
    wait_valid("multi_wait");
    expect_out("multi_code3", 5'b11110);
    ready = 1'b1;
    tick();
    expect_out("multi_accepted", 5'b01110);
    d0 = 1'b0;
    d3 = 1'b0;
    tick(12);
    expect_out("multi_idle", 5'b01110);
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    d0 = 1'b1;
    wait_valid("ovf_wait_d0");
    expect_out("ovf_first_event", 5'b10000);
    d1 = 1'b1;
    tick(12);
    expect_out("ovf_dropped", 5'b10001);
    ready = 1'b1;
    tick();
    expect_out("ovf_one_transfer", 5'b00001);
    tick(5);
    expect_out("ovf_stays_empty", 5'b00001);
    d0 = 1'b0;
    d1 = 1'b0;
    tick(12);
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    d1 = 1'b1;
    wait_valid("b2b_wait_d1");
    expect_out("b2b_hold_d1", 5'b10101);
    d3 = 1'b1;
    tick(6);
    expect_out("b2b_before_edge", 5'b10101);
    ready = 1'b1;
    tick();
    expect_out("b2b_new_code", 5'b11101);
    tick();
    expect_out("b2b_drained", 5'b01101);
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    d1 = 1'b0;
    d3 = 1'b0;
    tick(12);
    d2 = 1'b1;
    wait_valid("rst_wait_d2");
    expect_out("rst_pre_state", 5'b11001);
    #2;
    rst = 1'b1;
    d2  = 1'b0;
    #1;
    expect_out("rst_async_clear", 5'b00000);
    tick(2);
    rst = 1'b0;
    ready = 1'b1;
    tick(15);
    expect_out("rst_no_event_after", 5'b00000);
  endtask

  task automatic test_high_at_release();
    rst = 1'b1;
    d0  = 1'b1;
    tick(2);
    rst = 1'b0;
    ready = 1'b0;
    tick(6);
    expect_out("release_not_early", 5'b00000);
    tick();
    expect_out("release_event_d0", 5'b10000);
    ready = 1'b1;
    tick(12);
    expect_out("release_single_event", 5'b00000);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_multi();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_high_at_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_4to2_sync.md
ENCODER_4TO2_SYNC -- requirements
Module: encoder_4to2_sync

Interface
REQ-001 The block SHALL have parameter DEB, default 4, giving the debounce length in clock cycles (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset: one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have ports d0, d1, d2, d3  input  1 each  asynchronous request lines; d3 is highest priority.
REQ-005 The block SHALL have ports a, b  output  1 each  registered 2-bit event code, a = MSB, b = LSB (code n = line dn).
REQ-006 The block SHALL have port valid  output  1  high while an unconsumed event is held in a, b.
REQ-007 The block SHALL have port ready  input  1  consumer accepts the event on any edge where valid and ready are both high.
REQ-008 The block SHALL have port multi  output  1  registered with a, b; high if more than one line rose in the captured cycle.
REQ-009 The block SHALL have port ovf  output  1  sticky flag: an event was dropped.

Function
REQ-010 Each dn SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Each line SHALL have a filtered level f[n] and a 4-bit counter: synced == f[n] -> counter cleared; synced != f[n] -> counter increments.
REQ-012 When synced != f[n] and the counter equals DEB-1, f[n] SHALL take the synced value and the counter SHALL clear on that edge.
REQ-013 A pulse shorter than DEB synchronized cycles SHALL never change f[n] and SHALL produce no event.
REQ-014 A rise event on line n SHALL be f[n]=1 with previous-cycle f[n]=0; falling edges SHALL produce no event.
REQ-015 When any rise is present, the captured code SHALL be that of the highest-numbered rising line; multi SHALL be 1 if two or more lines rise in the same cycle, else 0.
REQ-016 The output register (a, b, multi, valid) SHALL load a rise event when valid=0, or when valid=1 and ready=1 on that same edge.
REQ-017 When valid=1 and ready=0 and a rise event occurs, the event SHALL be dropped, a/b/multi SHALL hold, and ovf SHALL be set.
REQ-018 On an edge with valid=1, ready=1 and no rise event, valid SHALL fall to 0; a, b, multi SHALL hold their values.
REQ-019 While valid=1 and ready=0, a, b, multi and valid SHALL remain constant.
REQ-020 Latency: a level held stable from the first sampling edge E SHALL cause valid=1 after edge E+DEB+2 (no backpressure).
REQ-021 ovf SHALL clear only on reset.
REQ-022 Output-register states: EMPTY (valid=0) and FULL (valid=1); EMPTY->FULL on event; FULL->EMPTY on accept without event; FULL->FULL on accept with event (new code) or on drop.

Reset
REQ-023 While rst=1, synchronizers, f[], counters, previous-f, a, b, multi, valid and ovf SHALL all be 0.
REQ-024 Reset asserted mid-operation SHALL discard any held or in-filter event without producing a transfer.
REQ-025 A line already high at reset release SHALL produce one rise event after DEB+2 edges, since f[] restarts at 0.

Verification (DEB=4)
REQ-026 Stimulus: d2 raised and held, ready=1. Required: valid=1, a=1, b=0, multi=0 six edges after first sample; valid=0 on the next edge.
REQ-027 Stimulus: d1 pulsed high for 3 cycles. Required: valid stays 0, ovf stays 0.
REQ-028 Stimulus: d0 and d3 raised in the same cycle. Required: a=1, b=1, multi=1.
REQ-029 Stimulus: ready=0, d0 rises and then d1 rises. Required: a=0, b=0 held, ovf=1; after ready=1, one transfer, then valid=0.
REQ-030 Stimulus: accept and a new d3 rise on the same edge. Required: valid stays 1 and a=1, b=1 on the next cycle.
REQ-031 Stimulus: rst pulsed while valid=1 and ovf=1. Required: all outputs 0 immediately (asynchronous), and no event after release if all lines are low.
